equiv_sweep_checker: RTL and testbench
======================================

// Module: equiv_sweep_checker
// PURPOSE
//  Exhaustive equivalence sweeper for pairs of small combinational circuits.
//  Upstream, it drives every N_IN-bit input vector into a reference circuit and
//  a candidate circuit (e.g. two 2-pair bit-equality comparators: x1,y1,x2,y2 -> a).
//  Downstream, it samples both 1-bit outputs, counts mismatches and captures the
//  first failing vector. It reports pass/fail when the sweep completes.
// PARAMETERS
//  N_IN    4  width of the swept input vector (2^N_IN vectors per sweep)
//  SETTLE  1  cycles each vector is held; outputs compared on the last (>=1)
// PORTS
//  clk             in   1        rising-edge clock
//  rst_n           in   1        async active-low reset; synchronous deassert by integrator
//  start           in   1        request a sweep; honoured in IDLE/DONE, ignored while busy
//  abort           in   1        stop the sweep and return to IDLE; priority over start
//  vec_out         out  N_IN     vector to both circuits; [3]=x1 [2]=y1 [1]=x2 [0]=y2 when N_IN=4
//  a_ref           in   1        reference circuit output (combinational from vec_out)
//  a_dut           in   1        candidate circuit output (combinational from vec_out)
//  busy            out  1        high in APPLY
//  done            out  1        high in DONE; held until next start, abort or reset
//  pass            out  1        valid with done; 1 iff mismatch_cnt==0
//  mismatch_cnt    out  N_IN+1   mismatching vectors this sweep (max 2^N_IN, no wrap)
//  first_fail_vld  out  1        at least one mismatch seen this sweep
//  first_fail_vec  out  N_IN     vec_out of first mismatch; 0 while first_fail_vld=0
// BEHAVIOUR
//  Reset (async): state=IDLE. vec_out, mismatch_cnt, first_fail_vec, settle_cnt=0.
//   busy, done, pass, first_fail_vld=0. Reset mid-sweep discards all results at once.
//  All outputs are registered. vec_out changes only on clk edges.
//  FSM states: IDLE, APPLY, DONE.
//   IDLE -> APPLY: start=1 & abort=0. At that edge: vec_out=0, settle_cnt=0,
//     mismatch_cnt=0, first_fail_vld=0, first_fail_vec=0, done=0, pass=0.
//   APPLY: settle_cnt counts 0..SETTLE-1 for each vector.
//     Compare edge: the edge where settle_cnt==SETTLE-1. At that edge, sample a_ref^a_dut.
//     On a mismatch, mismatch_cnt+=1. If first_fail_vld=0, also capture first_fail_vec=vec_out
//     and set first_fail_vld=1.
//     At the same edge: if vec_out==2^N_IN-1, go to DONE. Otherwise vec_out+=1 and settle_cnt=0.
//     A mismatch on the final vector is counted before entering DONE.
//   APPLY -> IDLE: abort=1 at any edge. Counters and first_fail keep partial values.
//     done=0, pass=0, vec_out holds its value.
//   DONE: done=1; pass=(mismatch_cnt==0); vec_out holds 2^N_IN-1.
//     start=1 & abort=0 -> APPLY with the same clears as from IDLE. abort=1 -> IDLE.
//  Latency: start edge t0 -> busy=1 from t0. Sweep occupies 2^N_IN*SETTLE edges.
//   done=1 after edge t0+2^N_IN*SETTLE. For N_IN=4, SETTLE=1 that is 16 edges.
//  start held high through DONE restarts immediately. Back-to-back sweeps are legal.
//  Simultaneous start & abort: abort wins in every state.
// TESTING
//  1 a_dut=a_ref=(vec[3]~^vec[2])&(vec[1]~^vec[0]); pulse start
//    -> 16 busy cycles; done=1, pass=1, mismatch_cnt=0, first_fail_vld=0.
//  2 a_dut=a_ref^(vec==4'h5)
//    -> done, pass=0, mismatch_cnt=1, first_fail_vec=4'h5, first_fail_vld=1.
//  3 a_dut=~a_ref for all vectors -> mismatch_cnt=16 (5'h10, no wrap); first_fail_vec=4'h0.
//  4 Mismatch only at vec 4'hF -> mismatch_cnt=1 and first_fail_vec=4'hF, both visible with done.
//  5 SETTLE=3, identical outputs -> done after exactly 48 edges;
//    each vec_out value held for 3 cycles.
//  6 abort at vec 4'h7 -> IDLE next edge, busy=0, done=0.
//    rst_n low mid-sweep -> all outputs 0 immediately.
//    start during busy ignored; start during DONE clears counts and restarts.

Source files
------------

// File: rtl/equiv_sweep_checker.sv
// ----------------------------------------------------------------------------
// equiv_sweep_checker
//
// Exhaustive equivalence sweeper for two small combinational circuits. It
// drives every N_IN-bit input vector, in ascending order, into a reference and
// a candidate circuit. Each vector is held for SETTLE cycles, and the two 1-bit
// outputs are compared on the last of those cycles. The block counts the
// mismatching vectors and captures the first failing vector. It reports
// pass/fail when the sweep completes.
//
// Ports
//   clk_i             rising-edge clock
//   rst_ni            asynchronous active-low reset
//   start_i           request a sweep (honoured in idle/done, ignored while busy)
//   abort_i           stop the sweep and return to idle; wins over start_i
//   vec_out_o         vector driven to both circuits
//   a_ref_i           reference circuit output (combinational from vec_out_o)
//   a_dut_i           candidate circuit output (combinational from vec_out_o)
//   busy_o            high while vectors are being applied
//   done_o            high once a sweep has completed; held until start/abort/reset
//   pass_o            valid with done_o; 1 iff no mismatch was seen
//   mismatch_cnt_o    number of mismatching vectors in this sweep
//   first_fail_vld_o  at least one mismatch seen in this sweep
//   first_fail_vec_o  vector of the first mismatch; 0 while first_fail_vld_o=0
// ----------------------------------------------------------------------------
module equiv_sweep_checker #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            abort_i,
    output logic [N_IN-1:0] vec_out_o,
    input  logic            a_ref_i,
    input  logic            a_dut_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [N_IN:0]   mismatch_cnt_o,
    output logic            first_fail_vld_o,
    output logic [N_IN-1:0] first_fail_vec_o
);

    // The settle counter needs at least one bit, even when SETTLE == 1.
    localparam int unsigned     SetW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VecLast    = '1;

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [SetW-1:0]   settle_q, settle_d;
    logic [N_IN:0]     cnt_q, cnt_d;
    logic              ff_vld_q, ff_vld_d;
    logic [N_IN-1:0]   ff_vec_q, ff_vec_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic              mismatch;
    logic              compare_edge;

    assign mismatch     = a_ref_i ^ a_dut_i;
    assign compare_edge = (settle_q == SettleLast);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        ff_vld_d = ff_vld_q;
        ff_vec_d = ff_vec_q;
        pass_d   = pass_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (abort_i) begin
                    // Results are kept for inspection; only the done/pass flags drop.
                    state_d = StIdle;
                    pass_d  = 1'b0;
                end else if (start_i) begin
                    state_d  = StApply;
                    vec_d    = '0;
                    settle_d = '0;
                    cnt_d    = '0;
                    ff_vld_d = 1'b0;
                    ff_vec_d = '0;
                    pass_d   = 1'b0;
                end
            end

            StApply: begin
                if (abort_i) begin
                    // Partial counts and vec_out stay where the sweep stopped.
                    state_d = StIdle;
                    pass_d  = 1'b0;
                end else if (compare_edge) begin
                    if (mismatch) begin
                        cnt_d = cnt_q + (N_IN + 1)'(1);
                        if (!ff_vld_q) begin
                            ff_vld_d = 1'b1;
                            ff_vec_d = vec_q;
                        end
                    end
                    if (vec_q == VecLast) begin
                        // cnt_d already includes a mismatch on the final vector.
                        state_d = StDone;
                        pass_d  = (cnt_d == '0);
                    end else begin
                        vec_d    = vec_q + N_IN'(1);
                        settle_d = '0;
                    end
                end else begin
                    settle_d = settle_q + SetW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                pass_d  = 1'b0;
            end
        endcase

        // Status flags are registered copies of the next state.
        busy_d = (state_d == StApply);
        done_d = (state_d == StDone);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            vec_q    <= '0;
            settle_q <= '0;
            cnt_q    <= '0;
            ff_vld_q <= 1'b0;
            ff_vec_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            ff_vld_q <= ff_vld_d;
            ff_vec_q <= ff_vec_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign vec_out_o        = vec_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign mismatch_cnt_o   = cnt_q;
    assign first_fail_vld_o = ff_vld_q;
    assign first_fail_vec_o = ff_vec_q;

endmodule

// File: tb/tb_equiv_sweep_checker.sv
// ----------------------------------------------------------------------------
// tb_equiv_sweep_checker
//
// Self-checking bench for equiv_sweep_checker. Two instances are used: one with
// SETTLE=1 and one with SETTLE=3. The candidate circuit is the reference 2-pair
// equality comparator with its output flipped wherever a 16-bit fault mask has
// a 1. Expected results come from sweeping the mask over all vectors in a plain
// loop.
// ----------------------------------------------------------------------------
module tb_equiv_sweep_checker;

    logic clk;
    logic rst_n;

    logic       start1, abort1, a_ref1, a_dut1;
    logic [3:0] vec1, ffvec1;
    logic       busy1, done1, pass1, ffv1;
    logic [4:0] cnt1;

    logic       start3, abort3, a_ref3, a_dut3;
    logic [3:0] vec3, ffvec3;
    logic       busy3, done3, pass3, ffv3;
    logic [4:0] cnt3;

    logic [15:0] mask1, mask3;

    int n_vec;
    int n_err;

    equiv_sweep_checker #(.N_IN(4), .SETTLE(1)) u_dut1 (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start1),
        .abort_i          (abort1),
        .vec_out_o        (vec1),
        .a_ref_i          (a_ref1),
        .a_dut_i          (a_dut1),
        .busy_o           (busy1),
        .done_o           (done1),
        .pass_o           (pass1),
        .mismatch_cnt_o   (cnt1),
        .first_fail_vld_o (ffv1),
        .first_fail_vec_o (ffvec1)
    );

    equiv_sweep_checker #(.N_IN(4), .SETTLE(3)) u_dut3 (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .start_i          (start3),
        .abort_i          (abort3),
        .vec_out_o        (vec3),
        .a_ref_i          (a_ref3),
        .a_dut_i          (a_dut3),
        .busy_o           (busy3),
        .done_o           (done3),
        .pass_o           (pass3),
        .mismatch_cnt_o   (cnt3),
        .first_fail_vld_o (ffv3),
        .first_fail_vec_o (ffvec3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: x1==y1 && x2==y2.
    function automatic logic ref_fn(input logic [3:0] v);
        return (v[3] == v[2]) && (v[1] == v[0]);
    endfunction

    // Candidate: reference output flipped on every vector selected by the mask.
    function automatic logic cand_fn(input logic [3:0] v, input logic [15:0] mask);
        return ref_fn(v) ^ mask[v];
    endfunction

    always_comb begin
        a_ref1 = ref_fn(vec1);
        a_dut1 = cand_fn(vec1, mask1);
        a_ref3 = ref_fn(vec3);
        a_dut3 = cand_fn(vec3, mask3);
    end

    // Expected results for vectors 0..upto-1 of a sweep.
    task automatic model(input logic [15:0] mask, input int upto, output int cnt,
                         output bit vld, output logic [3:0] fvec);
        logic [3:0] vv;
        cnt  = 0;
        vld  = 1'b0;
        fvec = 4'h0;
        for (int v = 0; v < upto; v++) begin
            vv = v[3:0];
            if (ref_fn(vv) != cand_fn(vv, mask)) begin
                cnt++;
                if (!vld) begin
                    vld  = 1'b1;
                    fvec = vv;
                end
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Full sweep on the SETTLE=1 instance, called at a negedge. Optionally pulses
    // start mid-sweep, which must be ignored.
    task automatic sweep1(input logic [15:0] mask, input bit poke_start);
        int         ecnt;
        bit         ev;
        logic [3:0] evec;
        mask1 = mask;
        model(mask, 16, ecnt, ev, evec);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check_val("clr_cnt", cnt1, 0);
        check_val("clr_ffv", ffv1, 0);
        check_val("clr_ffvec", ffvec1, 0);
        check_val("clr_done", done1, 0);
        check_val("clr_pass", pass1, 0);
        for (int i = 0; i < 16; i++) begin
            check_val("sweep_busy", busy1, 1);
            check_val("sweep_vec", vec1, i);
            start1 = poke_start && (i == 8);
            @(negedge clk);
        end
        start1 = 1'b0;
        check_val("end_done", done1, 1);
        check_val("end_busy", busy1, 0);
        check_val("end_pass", pass1, (ecnt == 0));
        check_val("end_cnt", cnt1, ecnt);
        check_val("end_ffv", ffv1, ev);
        check_val("end_ffvec", ffvec1, evec);
        check_val("end_vec", vec1, 4'hF);
        @(negedge clk);
        check_val("done_hold", done1, 1);
    endtask

    initial begin
        int         ecnt;
        bit         ev;
        logic [3:0] evec;
        logic [15:0] m;

        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        start1 = 1'b0;
        abort1 = 1'b0;
        start3 = 1'b0;
        abort3 = 1'b0;
        mask1  = 16'h0;
        mask3  = 16'h0;

        repeat (2) @(negedge clk);
        check_val("rst_vec", vec1, 0);
        check_val("rst_busy", busy1, 0);
        check_val("rst_done", done1, 0);
        check_val("rst_pass", pass1, 0);
        check_val("rst_cnt", cnt1, 0);
        check_val("rst_ffv", ffv1, 0);
        check_val("rst_ffvec", ffvec1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed fault patterns: none, single at 5, all, single at F.
        sweep1(16'h0000, 1'b0);
        sweep1(16'h0020, 1'b0);
        sweep1(16'hFFFF, 1'b0);
        sweep1(16'h8000, 1'b0);

        // Random fault patterns, back-to-back from DONE; one with a mid-sweep start.
        for (int k = 0; k < 8; k++) begin
            m = 16'($urandom);
            if (k % 2 == 1) m = m & 16'($urandom);
            sweep1(m, k == 3);
        end

        // Start held high: DONE, then immediate restart on the next edge.
        mask1  = 16'h0400;
        start1 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) @(negedge clk);
        check_val("held_done", done1, 1);
        check_val("held_cnt", cnt1, 1);
        @(negedge clk);
        check_val("held_restart_busy", busy1, 1);
        check_val("held_restart_vec", vec1, 0);
        check_val("held_restart_done", done1, 0);
        start1 = 1'b0;
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        check_val("held_abort_busy", busy1, 0);

        // Abort while vector 7 is applied: partial results over vectors 0..6.
        m = 16'($urandom) | 16'h00C0;
        mask1 = m;
        model(m, 7, ecnt, ev, evec);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        check_val("pre_abort_vec", vec1, 7);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        check_val("abort_busy", busy1, 0);
        check_val("abort_done", done1, 0);
        check_val("abort_pass", pass1, 0);
        check_val("abort_vec", vec1, 7);
        check_val("abort_cnt", cnt1, ecnt);
        check_val("abort_ffv", ffv1, ev);
        check_val("abort_ffvec", ffvec1, evec);
        @(negedge clk);
        check_val("idle_hold_vec", vec1, 7);

        // Simultaneous start and abort in IDLE: abort wins.
        start1 = 1'b1;
        abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        abort1 = 1'b0;
        check_val("sa_idle_busy", busy1, 0);

        // Simultaneous start and abort in DONE: back to IDLE.
        sweep1(16'h0001, 1'b0);
        start1 = 1'b1;
        abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        abort1 = 1'b0;
        check_val("sa_done_done", done1, 0);
        check_val("sa_done_busy", busy1, 0);
        check_val("sa_done_pass", pass1, 0);

        // SETTLE=3: each vector held three cycles, done after 48 edges.
        for (int k = 0; k < 2; k++) begin
            m = (k == 0) ? 16'h0 : 16'($urandom);
            mask3 = m;
            model(m, 16, ecnt, ev, evec);
            start3 = 1'b1;
            @(negedge clk);
            start3 = 1'b0;
            for (int i = 0; i < 48; i++) begin
                check_val("s3_busy", busy3, 1);
                check_val("s3_vec", vec3, i / 3);
                @(negedge clk);
            end
            check_val("s3_done", done3, 1);
            check_val("s3_pass", pass3, (ecnt == 0));
            check_val("s3_cnt", cnt3, ecnt);
            check_val("s3_ffv", ffv3, ev);
            check_val("s3_ffvec", ffvec3, evec);
        end

        // Reset mid-sweep clears everything immediately.
        mask1  = 16'h000F;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (6) @(negedge clk);
        check_val("pre_rst_cnt", cnt1, 4);
        #2 rst_n = 1'b0;
        #1;
        check_val("mrst_vec", vec1, 0);
        check_val("mrst_busy", busy1, 0);
        check_val("mrst_done", done1, 0);
        check_val("mrst_pass", pass1, 0);
        check_val("mrst_cnt", cnt1, 0);
        check_val("mrst_ffv", ffv1, 0);
        check_val("mrst_ffvec", ffvec1, 0);
        check_val("mrst_done3", done3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_busy", busy1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
